// File: rtl/wavelet_threshold_engine.sv
// wavelet_threshold_engine
//   Multi-level detail-coefficient thresholding stage for the DWT denoise path.
//   Every sample carries its decomposition level. Each level has its own
//   runtime-programmable threshold T. Per sample the engine applies hard,
//   soft, bypass or force-zero mode in a 2-stage valid/ready pipeline.
//   Optional macro THRESH_STATS_EN builds the per-window kept-coefficient
//   counter. Without it, kept_count and stats_valid are tied to 0.
//
// Ports
//   clk, rst           : clock; asynchronous active-high reset
//   in_valid/in_ready  : input handshake; in_ready = out_ready | ~out_valid
//   in_detail          : signed coefficient (ADC_WIDTH)
//   in_level, in_mode  : level index; mode 00 hard, 01 soft, 10 bypass, 11 zero
//   in_last            : last sample of window
//   thr_wr_*           : threshold register write port (unsigned magnitude)
//   out_valid/out_ready: output handshake
//   out_detail/out_level/out_last : thresholded sample and carried sideband
//   kept_count, stats_valid       : nonzero outputs in last window, update pulse
module wavelet_threshold_engine #(
  parameter  int ADC_WIDTH       = 14,
  parameter  int NUM_LEVELS      = 4,
  parameter  int MAX_WINDOW_SIZE = 1024,
  localparam int LEVEL_W         = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int CNT_W           = $clog2(MAX_WINDOW_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADC_WIDTH-1:0] in_detail,
  input  logic [LEVEL_W-1:0]   in_level,
  input  logic [1:0]           in_mode,
  input  logic                 in_last,
  input  logic                 thr_wr_en,
  input  logic [LEVEL_W-1:0]   thr_wr_level,
  input  logic [ADC_WIDTH-2:0] thr_wr_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADC_WIDTH-1:0] out_detail,
  output logic [LEVEL_W-1:0]   out_level,
  output logic                 out_last,
  output logic [CNT_W-1:0]     kept_count,
  output logic                 stats_valid
);

  typedef enum logic [1:0] {
    MODE_HARD   = 2'b00,
    MODE_SOFT   = 2'b01,
    MODE_BYPASS = 2'b10,
    MODE_ZERO   = 2'b11
  } mode_e;

  logic                 w_adv;
  logic [ADC_WIDTH-2:0] r_thr [NUM_LEVELS];
  logic [ADC_WIDTH-2:0] w_thr_lookup;
  logic                 w_lvl_ok;

  logic                 r_s1_valid;
  logic [ADC_WIDTH-1:0] r_s1_x;
  mode_e                r_s1_mode;
  logic [LEVEL_W-1:0]   r_s1_level;
  logic [ADC_WIDTH-2:0] r_s1_thr;
  logic                 r_s1_last;

  logic signed [ADC_WIDTH:0] w_x_ext;
  logic signed [ADC_WIDTH:0] w_t_ext;
  logic        [ADC_WIDTH:0] w_mag;
  logic [ADC_WIDTH-1:0]      w_res;

  // Whole pipeline moves as one unit; it only holds when the output is stuck.
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // Out-of-range level indices match no register: writes are dropped and
  // samples are demoted to force-zero.
  always_comb begin
    w_thr_lookup = '0;
    w_lvl_ok     = 1'b0;
    for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
      if (in_level == LEVEL_W'(i)) begin
        w_thr_lookup = r_thr[i];
        w_lvl_ok     = 1'b1;
      end
    end
  end

  // Threshold writes land at the clock edge, so a sample accepted in the same
  // cycle has already latched the old value through the lookup above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LEVELS; i++) r_thr[i] <= '0;
    end else if (thr_wr_en) begin
      for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
        if (thr_wr_level == LEVEL_W'(i)) r_thr[i] <= thr_wr_value;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_mode  <= MODE_HARD;
      r_s1_level <= '0;
      r_s1_thr   <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_x     <= in_detail;
      r_s1_mode  <= w_lvl_ok ? mode_e'(in_mode) : MODE_ZERO;
      r_s1_level <= in_level;
      r_s1_thr   <= w_thr_lookup;
      r_s1_last  <= in_last;
    end
  end

  // One extra bit keeps |x| and x +/- T exact, including x = -2^(ADC_WIDTH-1).
  always_comb begin
    w_x_ext = {r_s1_x[ADC_WIDTH-1], r_s1_x};
    w_t_ext = {1'b0, r_s1_thr};
    w_mag   = w_x_ext[ADC_WIDTH] ? -w_x_ext : w_x_ext;
    w_res   = '0;
    case (r_s1_mode)
      MODE_HARD:   w_res = (w_mag >= $unsigned(w_t_ext)) ? r_s1_x : '0;
      MODE_SOFT: begin
        if (w_x_ext >= w_t_ext)       w_res = ADC_WIDTH'(w_x_ext - w_t_ext);
        else if (w_x_ext <= -w_t_ext) w_res = ADC_WIDTH'(w_x_ext + w_t_ext);
        else                          w_res = '0;
      end
      MODE_BYPASS: w_res = r_s1_x;
      default:     w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_detail <= '0;
      out_level  <= '0;
      out_last   <= 1'b0;
    end else if (w_adv) begin
      out_valid  <= r_s1_valid;
      out_detail <= w_res;
      out_level  <= r_s1_level;
      out_last   <= r_s1_last;
    end
  end

`ifdef THRESH_STATS_EN
  logic             w_hs;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  always_comb begin
    w_hs      = out_valid & out_ready;
    w_cnt_inc = r_cnt;
    if (out_detail != '0 && r_cnt != '1) w_cnt_inc = r_cnt + 1'b1;
  end

  // The last sample's own contribution is folded into kept_count directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      kept_count  <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (w_hs) begin
        if (out_last) begin
          kept_count  <= w_cnt_inc;
          stats_valid <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end
`else
  assign kept_count  = '0;
  assign stats_valid = 1'b0;
`endif

endmodule

// File: doc/wavelet_threshold_engine.md
Name: wavelet_threshold_engine

Overview:
Multi-level detail-coefficient thresholding stage for the DWT denoise path. It sits between the forward-transform detail outputs and the inverse transform. Each coefficient carries its decomposition level, and each level has its own runtime-programmable threshold. Per sample it applies hard, soft, bypass or zero mode through a 2-stage valid/ready pipeline, and reports the count of surviving coefficients per window.

Parameters:
ADC_WIDTH, 14, coefficient width (signed two's complement)
NUM_LEVELS, 4, number of decomposition levels (≥1), one threshold register each
MAX_WINDOW_SIZE, 1024, max samples per window; sizes statistics counter
LEVEL_W, $clog2(NUM_LEVELS) min 1, localparam: level index width
CNT_W, $clog2(MAX_WINDOW_SIZE)+1, localparam: kept-count width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  engine can accept sample this cycle
in_detail  in  ADC_WIDTH  signed detail coefficient
in_level  in  LEVEL_W  decomposition level of sample
in_mode  in  2  00 hard, 01 soft, 10 bypass, 11 force-zero; sampled with data
in_last  in  1  last sample of window
thr_wr_en  in  1  threshold register write strobe
thr_wr_level  in  LEVEL_W  level to write
thr_wr_value  in  ADC_WIDTH-1  unsigned threshold magnitude T
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_detail  out  ADC_WIDTH  signed thresholded coefficient
out_level  out  LEVEL_W  level carried through
out_last  out  1  in_last carried through
kept_count  out  CNT_W  nonzero outputs in last completed window
stats_valid  out  1  one-cycle pulse when kept_count updates

Behaviour:
- Reset: all outputs 0, stage valids 0, threshold regs 0, running count 0.
- Pipeline: S1 registers sample, mode, level and looked-up T; S2 computes result into output regs. Latency is 2 cycles, in-acceptance to out_valid, with no stall.
- Advance enable: adv = out_ready | ~out_valid. S1 and S2 move only on adv; in_ready = adv (combinational). A transfer occurs when in_valid & in_ready.
- Under stall, all stage contents hold and out_* stay stable while out_valid & ~out_ready.
- Full throughput: 1 sample/cycle when out_ready is held high.
- Threshold regs: written on thr_wr_en. A write and a sample of the same level accepted in the same cycle → the sample uses the OLD T. T is looked up at S1 capture; later writes never affect in-flight samples. thr_wr_level ≥ NUM_LEVELS: write ignored. A sample with in_level ≥ NUM_LEVELS is treated as force-zero.
- Arithmetic: compute in ADC_WIDTH+1 bits signed, T zero-extended.
  - hard: |x| ≥ T → x, else 0.
  - soft: x ≥ T → x−T; x ≤ −T → x+T; else 0.
  - bypass → x. force-zero → 0.
  - Boundaries: |x| == T gives hard x, soft 0. T = 0 passes x in both hard and soft. x = −2^(ADC_WIDTH−1) is handled without overflow; the soft result −2^(ADC_WIDTH−1)+T always fits.
- Statistics: the running count increments on each output handshake (out_valid & out_ready) with out_detail ≠ 0. On the handshake of an out_last sample, kept_count takes the final count including that sample, stats_valid pulses 1 cycle, and the running count clears to 0.
- Count saturates at 2^CNT_W−1.
- Reset mid-window discards all in-flight samples and the partial count.

Optional Feature:
THRESH_STATS_EN: when defined, the statistics counter, kept_count and stats_valid logic are built as above. When undefined, there is no counter logic, kept_count is tied to 0 and stats_valid to 0. Data path and handshake are unchanged.

Test Plan:
- Reset then idle → out_valid=0, kept_count=0, in_ready=1. Write T[1]=100; send level 1 hard x=150,100,99,−100,−101 → outputs 150,100,0,−100,−101 exactly 2 cycles after each accept.
- T[2]=100, soft mode, level 2, x=150,100,−130,50 with in_last on the final sample → outputs 50,0,−30,0. stats_valid pulses with kept_count=2 (with THRESH_STATS_EN).
- ADC_WIDTH=14, T[0]=8191, soft, x=−8192 → out −1. Same x in hard mode → −8192. Bypass x=−8192 → −8192.
- Stream 6 samples with out_ready low for cycles 3–5 → in_ready low during stall, out_detail/out_level/out_last held stable, no sample lost or duplicated, order preserved.
- Same cycle: thr_wr_en writes T[0] 10→200 while accepting level 0 hard x=50 → out 50. Next level 0 sample x=50 → out 0.
- Assert rst with 2 samples in flight and count=3 → out_valid drops immediately. After release, a 1-sample window x=5, T=0 gives kept_count=1.
